mitchell_operand_encoder: RTL and testbench



---
 rtl/mitchell_operand_encoder.sv | 128 ++++++++++++
 tb/tb_mitchell_operand_encoder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mitchell_operand_encoder.sv
// Two-stage operand front-end for a Mitchell log multiplier: stage 1 finds the
// leading-one index and zero flag, stage 2 left-justifies the fraction below it.
module mitchell_operand_encoder #(
  parameter int A_BW = 32,
  parameter int B_BW = 32,
  localparam int AKW = $clog2(A_BW),
  localparam int BKW = $clog2(B_BW)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [A_BW-1:0] A,
  input  logic [B_BW-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [AKW-1:0]  k_1,
  output logic [BKW-1:0]  k_2,
  output logic [A_BW-1:0] x_1,
  output logic [B_BW-1:0] x_2,
  output logic            A_zero_flag,
  output logic            B_zero_flag
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid and its data hold steady until that transfer completes.
  logic s1_valid;
  logic s2_valid;
  logic s1_advance;
  logic s2_advance;
  logic accept;

  assign s2_advance = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_advance;
  assign in_ready   = !s1_valid || s2_advance;
  assign accept     = in_valid && in_ready;
  assign out_valid  = s2_valid;

  // Stage 1 combinational: leading-one priority encoders on the raw inputs.
  logic [AKW-1:0] a_k;
  logic [BKW-1:0] b_k;
  logic           a_zero;
  logic           b_zero;

  always_comb begin
    a_k    = '0;
    a_zero = (A == '0);
    for (int i = 0; i < A_BW; i++) begin
      if (A[i]) a_k = AKW'(i);
    end
  end

  always_comb begin
    b_k    = '0;
    b_zero = (B == '0);
    for (int i = 0; i < B_BW; i++) begin
      if (B[i]) b_k = BKW'(i);
    end
  end

  logic [A_BW-1:0] s1_a;
  logic [B_BW-1:0] s1_b;
  logic [AKW-1:0]  s1_ka;
  logic [BKW-1:0]  s1_kb;
  logic            s1_za;
  logic            s1_zb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_ka    <= '0;
      s1_kb    <= '0;
      s1_za    <= 1'b0;
      s1_zb    <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_a     <= A;
        s1_b     <= B;
        s1_ka    <= a_k;
        s1_kb    <= b_k;
        s1_za    <= a_zero;
        s1_zb    <= b_zero;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Shift by (BW-k) split into (BW-1-k) then 1 so the amount always fits in
  // k's width; k=0 therefore drops every bit, giving x=0 for operands 0 and 1.
  logic [AKW-1:0]  a_shamt;
  logic [BKW-1:0]  b_shamt;
  logic [A_BW-1:0] a_frac;
  logic [B_BW-1:0] b_frac;

  assign a_shamt = AKW'(A_BW - 1) - s1_ka;
  assign b_shamt = BKW'(B_BW - 1) - s1_kb;
  assign a_frac  = (s1_a << a_shamt) << 1;
  assign b_frac  = (s1_b << b_shamt) << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      k_1         <= '0;
      k_2         <= '0;
      x_1         <= '0;
      x_2         <= '0;
      A_zero_flag <= 1'b0;
      B_zero_flag <= 1'b0;
    end else begin
      if (s1_advance) begin
        s2_valid    <= 1'b1;
        k_1         <= s1_ka;
        k_2         <= s1_kb;
        x_1         <= a_frac;
        x_2         <= b_frac;
        A_zero_flag <= s1_za;
        B_zero_flag <= s1_zb;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mitchell_operand_encoder.sv
// Self-checking bench for mitchell_operand_encoder at 8-bit operand widths.
module tb_mitchell_operand_encoder;

  localparam int BW = 8;
  localparam int KW = 3;
  localparam int EW = 2 * KW + 2 * BW + 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] a;
  logic [BW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [KW-1:0] k_1;
  logic [KW-1:0] k_2;
  logic [BW-1:0] x_1;
  logic [BW-1:0] x_2;
  logic          a_zero_flag;
  logic          b_zero_flag;

  int tests_run = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs;

  mitchell_operand_encoder #(.A_BW(BW), .B_BW(BW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(a),
    .B(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .k_1(k_1),
    .k_2(k_2),
    .x_1(x_1),
    .x_2(x_2),
    .A_zero_flag(a_zero_flag),
    .B_zero_flag(b_zero_flag)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {k_1, k_2, x_1, x_2, a_zero_flag, b_zero_flag};

  // Reference: k is the highest set bit; x is the operand shifted left by BW-k
  // and truncated to BW bits.
  function automatic logic [KW-1:0] model_k(input logic [BW-1:0] v);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < BW; i++) if (v[i]) k = KW'(i);
    return k;
  endfunction

  function automatic logic [BW-1:0] model_x(input logic [BW-1:0] v);
    logic [2*BW-1:0] t;
    t = {{BW{1'b0}}, v} << (BW - int'(model_k(v)));
    return t[BW-1:0];
  endfunction

  function automatic logic [EW-1:0] model(input logic [BW-1:0] va, input logic [BW-1:0] vb);
    return {model_k(va), model_k(vb), model_x(va), model_x(vb), va == '0, vb == '0};
  endfunction

  // Scoreboard: every completed output handshake pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_unexpected: got %h, required no output", obs);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if (obs !== e) begin
          tests_failed++;
          $display("FAIL scoreboard_data: got %h, required %h", obs, e);
        end
      end
    end
  end

  // Driver: called at posedge+1; holds the pair until accepted, returns at
  // posedge+1 of the accepting edge with in_valid dropped.
  task automatic drive_pair(input logic [BW-1:0] va, input logic [BW-1:0] vb, output int waits);
    bit done;
    waits = 0;
    done = 0;
    a = va;
    b = vb;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(va, vb));
        done = 1;
      end else begin
        waits++;
        if (waits > 200) begin
          tests_run++;
          tests_failed++;
          $display("FAIL drive_timeout: in_ready stayed 0, required 1 within 200 cycles");
          done = 1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d outputs pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b, required 0", out_valid);
    end
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, required 0", obs);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic_encode();
    int w;
    out_ready = 1'b1;
    drive_pair(8'd12, 8'd5, w);
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_latency: out_valid got %b, required 1", out_valid);
    end
    tests_run++;
    if (obs !== {3'd3, 3'd2, 8'h80, 8'h40, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_12_5: got %h, required %h", obs, {3'd3, 3'd2, 8'h80, 8'h40, 1'b0, 1'b0});
    end
    wait_drain();
  endtask

  task automatic test_edge_operands();
    int w;
    out_ready = 1'b1;
    drive_pair(8'd0, 8'd255, w);
    @(posedge clk);
    #1;
    tests_run++;
    if (obs !== {3'd0, 3'd7, 8'h00, 8'hFE, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL edge_0_255: got %h, required %h", obs, {3'd0, 3'd7, 8'h00, 8'hFE, 1'b1, 1'b0});
    end
    wait_drain();
    drive_pair(8'd1, 8'd128, w);
    @(posedge clk);
    #1;
    tests_run++;
    if (obs !== {3'd0, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL edge_1_128: got %h, required %h", obs, {3'd0, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0});
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int w;
    int stalls;
    stalls = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_pair(BW'($urandom_range(0, 255)), BW'($urandom_range(0, 255)), w);
      stalls += w;
      if (i != 15) in_valid = 1'b1;
    end
    tests_run++;
    if (stalls != 0) begin
      tests_failed++;
      $display("FAIL back_to_back_ready: stall cycles got %0d, required 0", stalls);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int w;
    logic [EW-1:0] first;
    out_ready = 1'b0;
    first = model(8'd200, 8'd3);
    drive_pair(8'd200, 8'd3, w);
    drive_pair(8'd77, 8'd0, w);
    a = 8'd19;
    b = 8'd64;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_in_ready: got %b, required 0", in_ready);
      end
      tests_run++;
      if (out_valid !== 1'b1 || obs !== first) begin
        tests_failed++;
        $display("FAIL backpressure_hold: got v=%b %h, required v=1 %h", out_valid, obs, first);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drive_pair(8'd19, 8'd64, w);
    wait_drain();
  endtask

  task automatic test_random_stall();
    int sent;
    int cycles;
    bit pending;
    logic [BW-1:0] va;
    logic [BW-1:0] vb;
    sent = 0;
    cycles = 0;
    pending = 0;
    va = '0;
    vb = '0;
    while ((sent < 1000 || exp_q.size() != 0) && cycles < 20000) begin
      if (!pending && sent < 1000 && $urandom_range(0, 1) == 1) begin
        va = BW'($urandom_range(0, 255));
        vb = BW'($urandom_range(0, 255));
        pending = 1;
      end
      a = va;
      b = vb;
      in_valid = pending;
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (pending && in_ready) begin
        exp_q.push_back(model(va, vb));
        pending = 0;
        sent++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tests_run++;
    if (sent != 1000 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL random_stall: sent %0d pending %0d, required 1000 sent 0 pending", sent, exp_q.size());
    end
  endtask

  task automatic test_reset_midstream();
    int w;
    out_ready = 1'b0;
    drive_pair(8'd99, 8'd250, w);
    drive_pair(8'd45, 8'd7, w);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_out_valid: got %b, required 0", out_valid);
    end
    tests_run++;
    if (obs !== '0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %h, required 0", obs);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_after: in_ready %b out_valid %b, required 1 and 0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    drive_pair(8'd6, 8'd3, w);
    @(posedge clk);
    #1;
    tests_run++;
    if (obs !== {3'd2, 3'd1, 8'h80, 8'h80, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midreset_6_3: got %h, required %h", obs, {3'd2, 3'd1, 8'h80, 8'h80, 1'b0, 1'b0});
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic_encode();
    test_edge_operands();
    test_back_to_back();
    test_backpressure();
    test_random_stall();
    test_reset_midstream();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
